mont_operand_sequencer: RTL and testbench

//  Upstream controller/operand generator for the 512-bit carry-save Montgomery adder (mpadder).

---
 rtl/mont_operand_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_mont_operand_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_operand_sequencer.sv
// Operand generator and control sequencer for the 512-bit carry-save
// Montgomery adder. Scans A one radix-16 digit per cycle, gates the B/M
// multiples, then walks the adder through carry-propagate conversion and
// repeated conditional subtraction before returning the reduced result.
module mont_operand_sequencer #(
  parameter int N       = 512,
  parameter int DIGIT   = 4,
  parameter int ITERS   = 128,
  parameter int MAX_SUB = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   A_in,
  input  logic [N-1:0]   B_in,
  input  logic [N-1:0]   M_in,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   result,
  output logic           sub_err,
  output logic           adder_resetn,
  output logic [N-1:0]   B0,
  output logic [N:0]     B1,
  output logic [N+1:0]   B2,
  output logic [N+2:0]   B3,
  output logic [N-1:0]   M0,
  output logic [N:0]     M1,
  output logic [N+1:0]   M2,
  output logic [N+2:0]   M3,
  output logic           c_doubleshift,
  output logic           subtract,
  output logic [3:0]     phase,
  input  logic           cZero,
  input  logic           cOne,
  input  logic           cTwo,
  input  logic           cThree,
  input  logic           subtract_finished,
  input  logic [N-1:0]   trueResult
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int RW = $clog2(MAX_SUB) + 1;
  localparam logic [3:0] PHASE_HOLD = 4'd8;
  localparam logic [3:0] PHASE_LAST = 4'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ITER  = 3'd2,
    CONV  = 3'd3,
    SUB   = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  a_sh_reg, a_sh_next;
  logic [N-1:0]  b_reg, b_next;
  logic [N-1:0]  m_reg, m_next;
  logic [CW-1:0] iter_cnt_reg, iter_cnt_next;
  logic [RW-1:0] round_cnt_reg, round_cnt_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          sub_err_reg, sub_err_next;
  logic [N-1:0]  result_reg, result_next;
  logic          clr_reg, clr_next;
  logic          dshift_reg, dshift_next;
  logic          subtract_reg, subtract_next;
  logic [3:0]    phase_reg, phase_next;

  logic          in_iter;
  logic [3:0]    digit;

  // State and registered outputs; async reset drops everything back to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_reg         <= '0;
      m_reg         <= '0;
      iter_cnt_reg  <= '0;
      round_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      sub_err_reg   <= 1'b0;
      result_reg    <= '0;
      clr_reg       <= 1'b0;
      dshift_reg    <= 1'b0;
      subtract_reg  <= 1'b0;
      phase_reg     <= PHASE_HOLD;
    end else begin
      state_reg     <= state_next;
      a_sh_reg      <= a_sh_next;
      b_reg         <= b_next;
      m_reg         <= m_next;
      iter_cnt_reg  <= iter_cnt_next;
      round_cnt_reg <= round_cnt_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      sub_err_reg   <= sub_err_next;
      result_reg    <= result_next;
      clr_reg       <= clr_next;
      dshift_reg    <= dshift_next;
      subtract_reg  <= subtract_next;
      phase_reg     <= phase_next;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_next     = state_reg;
    a_sh_next      = a_sh_reg;
    b_next         = b_reg;
    m_next         = m_reg;
    iter_cnt_next  = iter_cnt_reg;
    round_cnt_next = round_cnt_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    sub_err_next   = sub_err_reg;
    result_next    = result_reg;
    clr_next       = 1'b0;
    dshift_next    = dshift_reg;
    subtract_next  = subtract_reg;
    phase_next     = phase_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_sh_next    = A_in;
          b_next       = B_in;
          m_next       = M_in;
          clr_next     = 1'b1;
          busy_next    = 1'b1;
          sub_err_next = 1'b0;
          state_next   = CLEAR;
        end
      end
      CLEAR: begin
        iter_cnt_next = CW'(ITERS - 1);
        dshift_next   = 1'b1;
        phase_next    = PHASE_HOLD;
        subtract_next = 1'b0;
        state_next    = ITER;
      end
      ITER: begin
        a_sh_next = a_sh_reg >> DIGIT;
        if (iter_cnt_reg == '0) begin
          dshift_next = 1'b0;
          phase_next  = 4'd0;
          state_next  = CONV;
        end else begin
          iter_cnt_next = iter_cnt_reg - 1'b1;
        end
      end
      CONV: begin
        if (phase_reg == PHASE_LAST) begin
          phase_next     = 4'd0;
          subtract_next  = 1'b1;
          round_cnt_next = '0;
          state_next     = SUB;
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
      SUB: begin
        if (phase_reg == PHASE_LAST) begin
          round_cnt_next = round_cnt_reg + 1'b1;
          if (subtract_finished || (round_cnt_reg == RW'(MAX_SUB - 1))) begin
            if (!subtract_finished) begin
              sub_err_next = 1'b1;
            end
            result_next   = trueResult;
            done_next     = 1'b1;
            phase_next    = PHASE_HOLD;
            subtract_next = 1'b0;
            state_next    = FIN;
          end else begin
            phase_next = 4'd0;
          end
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
      FIN: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Multiples are only presented while the adder is accumulating.
  assign in_iter = (state_reg == ITER);
  assign digit   = a_sh_reg[3:0];

  assign B0 = (in_iter && digit[0]) ? b_reg           : '0;
  assign B1 = (in_iter && digit[1]) ? {b_reg, 1'b0}   : '0;
  assign B2 = (in_iter && digit[2]) ? {b_reg, 2'b00}  : '0;
  assign B3 = (in_iter && digit[3]) ? {b_reg, 3'b000} : '0;

  assign M0 = (in_iter && cZero)  ? m_reg           : '0;
  assign M1 = (in_iter && cOne)   ? {m_reg, 1'b0}   : '0;
  assign M2 = (in_iter && cTwo)   ? {m_reg, 2'b00}  : '0;
  assign M3 = (in_iter && cThree) ? {m_reg, 3'b000} : '0;

  // The clear pulse is registered, so gating it with resetn is glitch-free.
  assign adder_resetn  = resetn & ~clr_reg;

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign result        = result_reg;
  assign sub_err       = sub_err_reg;
  assign c_doubleshift = dshift_reg;
  assign subtract      = subtract_reg;
  assign phase         = phase_reg;

endmodule

// File: tb/tb_mont_operand_sequencer.sv
// Bench for mont_operand_sequencer: a behavioural adder closes the loop, and
// results are compared against a bit-serial Montgomery reference.
module tb_mont_operand_sequencer;
  localparam int N = 512;

  logic           clk, resetn, start;
  logic [N-1:0]   A_in, B_in, M_in;
  logic           busy, done, sub_err, adder_resetn;
  logic [N-1:0]   result;
  logic [N-1:0]   B0, M0;
  logic [N:0]     B1, M1;
  logic [N+1:0]   B2, M2;
  logic [N+2:0]   B3, M3;
  logic           c_doubleshift, subtract;
  logic [3:0]     phase;
  logic           cZero, cOne, cTwo, cThree, subtract_finished;
  logic [N-1:0]   trueResult;

  int checks = 0;
  int failures = 0;

  mont_operand_sequencer #(.N(N), .DIGIT(4), .ITERS(128), .MAX_SUB(4)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .A_in(A_in), .B_in(B_in), .M_in(M_in),
    .busy(busy), .done(done), .result(result), .sub_err(sub_err),
    .adder_resetn(adder_resetn),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .M0(M0), .M1(M1), .M2(M2), .M3(M3),
    .c_doubleshift(c_doubleshift), .subtract(subtract), .phase(phase),
    .cZero(cZero), .cOne(cOne), .cTwo(cTwo), .cThree(cThree),
    .subtract_finished(subtract_finished), .trueResult(trueResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural adder ----------------
  logic [N+7:0] acc, sum_b, sum_all, m_ext;
  logic [N-1:0] m_model;
  logic [3:0]   minv, neg_s, q;
  logic         force_unf;

  // Quotient digit chosen so the accumulated sum is divisible by 16.
  always_comb begin
    m_ext   = {8'b0, m_model};
    sum_b   = acc + (N+8)'(B0) + (N+8)'(B1) + (N+8)'(B2) + (N+8)'(B3);
    neg_s   = 4'd0 - sum_b[3:0];
    q       = neg_s * minv;
    sum_all = sum_b + (N+8)'(M0) + (N+8)'(M1) + (N+8)'(M2) + (N+8)'(M3);
    subtract_finished = subtract && (phase == 4'd5) && !force_unf && (acc < m_ext);
  end
  assign cZero  = q[0];
  assign cOne   = q[1];
  assign cTwo   = q[2];
  assign cThree = q[3];
  assign trueResult = acc[N-1:0];

  // Accumulate-and-shift during ITER; conditional subtract at phase 5.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) acc <= '0;
    else if (!adder_resetn) acc <= '0;
    else if (c_doubleshift) acc <= sum_all >> 4;
    else if (subtract && phase == 4'd5 && acc >= m_ext) acc <= acc - m_ext;
  end

  // ---------------- reference and helpers ----------------
  function automatic logic [N-1:0] mont_ref(input logic [N-1:0] a, b, m);
    logic [2*N-1:0] x;
    x = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % {{N{1'b0}}, m};
    for (int i = 0; i < N; i++) begin
      if (x[0]) x = x + {{N{1'b0}}, m};
      x = x >> 1;
    end
    return x[N-1:0];
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int i = 0; i < N/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_model(input logic [N-1:0] m);
    m_model = m;
    minv = 4'd1;
    for (int x = 1; x < 16; x += 2) begin
      logic [3:0] p;
      p = m[3:0] * 4'(x);
      if (p == 4'd1) minv = 4'(x);
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Follows one operation from its CLEAR cycle (k=1) until done, tallying
  // every cycle whose controls or gated multiples deviate from expectation.
  task automatic track(input logic [N-1:0] a, b, input int drop_at,
                       output int k, output int errs);
    logic [3:0] dig;
    logic in_it;
    k = 1;
    errs = 0;
    while (done !== 1'b1 && k < 400) begin
      if (k == drop_at) start = 1'b0;
      in_it = (k >= 2 && k <= 129);
      if (busy !== 1'b1) errs++;
      if (adder_resetn !== (k != 1)) errs++;
      if (c_doubleshift !== in_it) errs++;
      if (in_it) begin
        dig = a[4*(k-2) +: 4];
        if (B0 !== (dig[0] ? b : '0)) errs++;
        if (B1 !== (dig[1] ? {b, 1'b0} : '0)) errs++;
        if (B2 !== (dig[2] ? {b, 2'b00} : '0)) errs++;
        if (B3 !== (dig[3] ? {b, 3'b000} : '0)) errs++;
        if (M0 !== (cZero ? m_model : '0)) errs++;
        if (M1 !== (cOne ? {m_model, 1'b0} : '0)) errs++;
        if (M2 !== (cTwo ? {m_model, 2'b00} : '0)) errs++;
        if (M3 !== (cThree ? {m_model, 3'b000} : '0)) errs++;
        if (phase !== 4'd8 || subtract !== 1'b0) errs++;
      end else begin
        if (B0 !== '0 || B1 !== '0 || B2 !== '0 || B3 !== '0) errs++;
        if (M0 !== '0 || M1 !== '0 || M2 !== '0 || M3 !== '0) errs++;
      end
      if (k >= 130 && k <= 135 && (phase !== 4'(k-130) || subtract !== 1'b0)) errs++;
      if (k >= 136 && k <= 141 && (phase !== 4'(k-136) || subtract !== 1'b1)) errs++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, b, m, exp_res, input int exp_lat,
                        input logic exp_err, input bit chk_res, input string tag);
    int k, errs;
    set_model(m);
    A_in = a; B_in = b; M_in = m; start = 1'b1;
    @(negedge clk);
    track(a, b, 1, k, errs);
    chk({tag, "_done"}, done, 1);
    if (exp_lat != 0) chk({tag, "_latency"}, k, exp_lat);
    else chk({tag, "_latency"}, (k == 142 || k == 148), 1);
    if (chk_res) chk({tag, "_result"}, result, exp_res);
    chk({tag, "_sub_err"}, sub_err, exp_err);
    chk({tag, "_trace"}, errs, 0);
    chk({tag, "_fin_busy"}, busy, 1);
    $display("txn %s lat=%0d result_lo=%h sub_err=%0b", tag, k, result[31:0], sub_err);
    @(negedge clk);
    chk({tag, "_post_done"}, done, 0);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [N-1:0] a, b, m, res;
    int           lat;
  } vec_t;

  initial begin
    vec_t vtab[5];
    logic [N-1:0] mf1, a1, b1, m1, a2, b2, m2, ra, rb, rm;
    int k, errs;

    mf1 = '1; mf1[7:0] = 8'hF1;
    vtab[0] = '{a: '0, b: 1, m: mf1, res: '0, lat: 142};
    vtab[1] = '{a: 1,  b: 1, m: '1,  res: 1,  lat: 142};
    vtab[2] = '{a: 1,  b: 5, m: '1,  res: 5,  lat: 142};
    vtab[3] = '{a: '0, b: '0, m: mf1, res: '0, lat: 142};
    vtab[4] = '{a: '1, b: 1, m: '1,  res: '0, lat: 148};

    resetn = 1'b0; start = 1'b0; force_unf = 1'b0;
    A_in = '0; B_in = '0; M_in = '0;
    set_model('1);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sub_err", sub_err, 0);
    chk("rst_result", result, '0);
    chk("rst_phase", phase, 8);
    chk("rst_dshift", c_doubleshift, 0);
    chk("rst_subtract", subtract, 0);
    chk("rst_adder_resetn", adder_resetn, 0);
    chk("rst_B3", B3, '0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_adder_resetn", adder_resetn, 1);

    for (int i = 0; i < 5; i++)
      run_op(vtab[i].a, vtab[i].b, vtab[i].m, vtab[i].res, vtab[i].lat, 1'b0, 1'b1,
             $sformatf("vec%0d", i));

    // Adder never reports underflow: four rounds then sub_err.
    force_unf = 1'b1;
    run_op(1, 1, '1, '0, 160, 1'b1, 1'b0, "no_finish");
    force_unf = 1'b0;

    // Async reset in the middle of ITER.
    ra = rand_wide(); rm = rand_wide(); rm[N-1] = 1'b1; rm[0] = 1'b1; rb = rand_wide() % rm;
    set_model(rm);
    A_in = ra; B_in = rb; M_in = rm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (51) @(negedge clk);
    chk("mid_dshift_before", c_doubleshift, 1);
    resetn = 1'b0;
    #1;
    chk("arst_adder_resetn", adder_resetn, 0);
    chk("arst_busy", busy, 0);
    chk("arst_phase", phase, 8);
    chk("arst_dshift", c_doubleshift, 0);
    chk("arst_result", result, '0);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_idle_done", done, 0);
    run_op(ra, rb, rm, mont_ref(ra, rb, rm), 0, 1'b0, 1'b1, "after_rst");

    // start held through an operation and past its done pulse.
    a1 = rand_wide(); m1 = rand_wide(); m1[N-1] = 1'b1; m1[0] = 1'b1; b1 = rand_wide() % m1;
    a2 = rand_wide(); m2 = rand_wide(); m2[N-1] = 1'b1; m2[0] = 1'b1; b2 = rand_wide() % m2;
    set_model(m1);
    A_in = a1; B_in = b1; M_in = m1; start = 1'b1;
    @(negedge clk);
    track(a1, b1, 0, k, errs);
    chk("hold1_done", done, 1);
    chk("hold1_latency", (k == 142 || k == 148), 1);
    chk("hold1_result", result, mont_ref(a1, b1, m1));
    chk("hold1_trace", errs, 0);
    $display("txn hold1 lat=%0d result_lo=%h", k, result[31:0]);
    A_in = a2; B_in = b2; M_in = m2;
    set_model(m2);
    @(negedge clk);
    chk("hold_gap_busy", busy, 0);
    chk("hold_gap_done", done, 0);
    @(negedge clk);
    track(a2, b2, 3, k, errs);
    chk("hold2_done", done, 1);
    chk("hold2_latency", (k == 142 || k == 148), 1);
    chk("hold2_result", result, mont_ref(a2, b2, m2));
    chk("hold2_trace", errs, 0);
    $display("txn hold2 lat=%0d result_lo=%h", k, result[31:0]);
    @(negedge clk);
    chk("hold2_post_busy", busy, 0);

    // Random operands against the reference.
    for (int i = 0; i < 200; i++) begin
      ra = rand_wide(); rm = rand_wide(); rm[N-1] = 1'b1; rm[0] = 1'b1;
      rb = rand_wide() % rm;
      run_op(ra, rb, rm, mont_ref(ra, rb, rm), 0, 1'b0, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
